// File: rtl/uni_acc_dec.sv
// Unary-to-binary decoder: counts '1' samples of a unary bitstream over a
// window of 2^LOGLEN accepted samples and hands the count out via valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; inputs ignored
// S_COUNT | accumulating iBit on every iEn cycle until window is full
// S_DONE  | result held on oCnt with oValid=1 until consumer takes it
module uni_acc_dec #(
  parameter int LOGLEN = 8,
  parameter int CNTWD  = LOGLEN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             iEn,
  input  logic             iBit,
  output logic             oValid,
  input  logic             iReady,
  output logic [CNTWD-1:0] oCnt,
  output logic             oBusy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNTWD-1:0]  r_acc;
  logic [CNTWD-1:0]  r_cnt;
  logic [LOGLEN-1:0] r_smp;
  logic              r_valid;
  logic              r_busy;

  logic              w_clr;
  logic              w_take;
  logic              w_load;
  logic              w_last;
  logic [CNTWD-1:0]  w_acc_inc;

  // Sample counter wraps to zero on the last sample; the all-ones compare
  // marks the edge that accepts sample number 2^LOGLEN.
  assign w_last    = (r_smp == {LOGLEN{1'b1}});
  assign w_acc_inc = r_acc + {{(CNTWD-1){1'b0}}, iBit};

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_take      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_COUNT;
          w_clr       = 1'b1;
        end
      end
      S_COUNT: begin
        // start wins over sampling: the window restarts and iBit is dropped
        if (start) begin
          w_clr = 1'b1;
        end else if (iEn) begin
          w_take = 1'b1;
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_load      = 1'b1;
          end
        end
      end
      S_DONE: begin
        // start without iReady is ignored so the held result is never lost
        if (iReady) begin
          if (start) begin
            w_state_nxt = S_COUNT;
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_smp   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt == S_COUNT);
      if (w_clr) begin
        r_acc <= '0;
        r_smp <= '0;
      end else if (w_take) begin
        r_acc <= w_acc_inc;
        r_smp <= r_smp + 1'b1;
      end
      if (w_load) begin
        r_cnt <= w_acc_inc;
      end
    end
  end

  assign oValid = r_valid;
  assign oBusy  = r_busy;
  assign oCnt   = r_cnt;

endmodule
